// File: rtl/serial_arith_pkg.sv
// ---------------------------------------------------------------------------
// serial_arith_pkg
// Purpose: shared definitions for the bit-serial arithmetic blocks.
//   - state_e : FSM encodings (IDLE/SHIFT/DONE). Code 2'd3 is unused and is
//               steered back to IDLE by the FSM.
// ---------------------------------------------------------------------------
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : serial_arith_pkg

// File: rtl/bit_serial_addsub_if.sv
// ---------------------------------------------------------------------------
// bit_serial_addsub_if
// Purpose: request/result bundle of the bit-serial adder/subtractor.
//   start, sub, a, b : request side, driven by the master
//   busy, done       : status, driven by the slave
//   sum, cout, ovf   : result, driven by the slave (valid from done onward)
// ---------------------------------------------------------------------------
interface bit_serial_addsub_if #(
  parameter int WIDTH = 8
);
  import serial_arith_pkg::*;

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );

endinterface : bit_serial_addsub_if

// File: rtl/fa_nand.sv
// ---------------------------------------------------------------------------
// fa_nand
// Purpose: gate-level 1-bit full adder built from nine 2-input NANDs.
// Ports:
//   a_i, b_i, c_i : addend bits and carry-in
//   s_o           : sum bit
//   co_o          : carry-out
// ---------------------------------------------------------------------------
module fa_nand (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  logic n1_s, n2_s, n3_s, x1_s, n4_s, n5_s, n6_s;

  // First half: x1 = a ^ b from four NANDs
  assign n1_s = ~(a_i & b_i);
  assign n2_s = ~(a_i & n1_s);
  assign n3_s = ~(b_i & n1_s);
  assign x1_s = ~(n2_s & n3_s);

  // Second half: s = x1 ^ c; carry reuses n1 (a&b) and n4 (x1&c)
  assign n4_s = ~(x1_s & c_i);
  assign n5_s = ~(x1_s & n4_s);
  assign n6_s = ~(c_i & n4_s);
  assign s_o  = ~(n5_s & n6_s);
  assign co_o = ~(n4_s & n1_s);

endmodule : fa_nand

// File: rtl/bit_serial_addsub.sv
// ---------------------------------------------------------------------------
// bit_serial_addsub
// Purpose: WIDTH-bit adder/subtractor producing one result bit per clock,
//   LSB first, through a single fa_nand cell plus a carry flop.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of bit_serial_addsub_if (start/sub/a/b in,
//           busy/done/sum/cout/ovf out)
// Timing: start accepted at edge k gives done high in the cycle after edge
//   k+WIDTH; sum/cout/ovf then hold until the next accepted start.
// ---------------------------------------------------------------------------
module bit_serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  bit_serial_addsub_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic             fa_sum_s;
  logic             fa_cy_s;

  fa_nand u_fa (
    .a_i  (a_sr_q[0]),
    .b_i  (b_sr_q[0]),
    .c_i  (carry_q),
    .s_o  (fa_sum_s),
    .co_o (fa_cy_s)
  );

  // FSM, datapath shift registers and registered status/result flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry
            a_sr_q  <= bus.a;
            b_sr_q  <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          sum_q   <= {fa_sum_s, sum_q[WIDTH-1:1]};
          a_sr_q  <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q  <= {1'b0, b_sr_q[WIDTH-1:1]};
          carry_q <= fa_cy_s;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            // carry_q here is the carry into the MSB; fa_cy_s is carry out
            cout_q  <= fa_cy_s;
            ovf_q   <= carry_q ^ fa_cy_s;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule : bit_serial_addsub

// File: tb/tb_bit_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_addsub
// Purpose: directed, table-driven self-checking bench for bit_serial_addsub
//   at WIDTH=8, plus hand-written sequences for the ignored-restart and
//   mid-operation reset cases.
// ---------------------------------------------------------------------------
module tb_bit_serial_addsub;

  localparam int WIDTH = 8;

  typedef struct {
    string      name;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bit_serial_addsub_if #(.WIDTH(WIDTH)) bus ();

  bit_serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation and watch it for WIDTH+4 edges.
  // inj_at > 0 pulses start with different operands after that many edges.
  task automatic run_op(input vec_t v, input int inj_at);
    int lat;
    int pulses;
    lat    = 0;
    pulses = 0;
    bus.sub   = v.sub;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({v.name, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
    for (int i = 1; i <= WIDTH + 4; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        pulses++;
        if (lat == 0) lat = i;
      end
      if (i == 4) chk({v.name, "_busy_midway"}, 32'(bus.busy), 32'd1);
      if (inj_at > 0 && i == inj_at) begin
        bus.start = 1'b1;
        bus.sub   = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h77;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk({v.name, "_latency"}, 32'(lat), 32'(WIDTH));
    chk({v.name, "_done_pulses"}, 32'(pulses), 32'd1);
    chk({v.name, "_sum"}, 32'(bus.sum), 32'(v.exp_sum));
    chk({v.name, "_cout"}, 32'(bus.cout), 32'(v.exp_cout));
    chk({v.name, "_ovf"}, 32'(bus.ovf), 32'(v.exp_ovf));
    chk({v.name, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vec_t vecs[4];
    int   pulses;
    checks   = 0;
    failures = 0;

    vecs[0] = '{"add_5A_3C", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{"add_FF_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{"sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
    vecs[3] = '{"sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum",  32'(bus.sum),  32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_ovf",  32'(bus.ovf),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i], 0);
    end

    // Restart during bit-cycle 3 must be ignored
    run_op(vecs[0], 3);

    // Reset during bit-cycle 4 aborts without a done pulse
    bus.sub   = 1'b1;
    bus.a     = 8'h80;
    bus.b     = 8'h01;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_sum",  32'(bus.sum),  32'd0);
    chk("midrst_cout", 32'(bus.cout), 32'd0);
    chk("midrst_ovf",  32'(bus.ovf),  32'd0);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) pulses++;
    end
    chk("midrst_no_activity", 32'(pulses), 32'd0);

    // Fresh operation after the aborted one
    run_op(vecs[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bit_serial_addsub
